// File: rtl/pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_streamer
//  Purpose  : Reads one WIDTH x HEIGHT greyscale frame from a synchronous frame
//             RAM in raster order and presents it as a valid/ready pixel
//             stream with start-of-frame, end-of-line and end-of-frame markers.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_streamer #(
    parameter int WIDTH  = 3,
    parameter int HEIGHT = 3,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              sof,
    output logic              eol,
    output logic              eof
);

    // Counter widths; a one-pixel dimension still gets a 1-bit counter.
    localparam int c_XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int c_YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    // Buffer entry layout: {sof, eol, eof, pixel}.
    localparam int c_EW = PIX_W + 3;

    localparam logic [c_XW-1:0]   c_X_LAST = c_XW'(WIDTH - 1);
    localparam logic [c_YW-1:0]   c_Y_LAST = c_YW'(HEIGHT - 1);
    // Read counter is one bit wider than the address so it can hold the
    // full pixel count even when the frame exactly fills the RAM.
    localparam logic [ADDR_W:0]   c_NPIX   = (ADDR_W + 1)'(WIDTH * HEIGHT);
    localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [c_XW-1:0]   c_X_ONE  = c_XW'(1);
    localparam logic [c_YW-1:0]   c_Y_ONE  = c_YW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [ADDR_W:0]  r_rd_cnt;
    logic [c_XW-1:0]  r_x;
    logic [c_YW-1:0]  r_y;
    logic             r_inflight;
    logic [2:0]       r_if_mk;
    logic             r_out_v;
    logic [c_EW-1:0]  r_out;
    logic             r_skid_v;
    logic [c_EW-1:0]  r_skid;

    logic             w_run;
    logic             w_start;
    logic             w_room;
    logic             w_rd_en;
    logic [2:0]       w_mk;
    logic [c_EW-1:0]  w_in;
    logic [c_EW-1:0]  w_head;
    logic             w_xfer;

    // Read issue, stream head selection and marker generation.
    always_comb begin
        w_run   = (r_state == c_RUN);
        w_start = (r_state == c_IDLE) && start;
        // At most two pixels may be held or in flight at any time: the
        // only way to reach two is an occupied output register together
        // with either a skid entry or a pending RAM read.
        w_room  = !(r_out_v && (r_skid_v || r_inflight));
        w_rd_en = w_run && (r_rd_cnt < c_NPIX) && w_room;
        // Markers belong to the raster position of the pixel being read.
        w_mk[2] = (r_x == '0) && (r_y == '0);
        w_mk[1] = (r_x == c_X_LAST);
        w_mk[0] = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
        // RAM data arriving this cycle, tagged with the markers captured
        // when its read was issued.
        w_in    = {r_if_mk, mem_rd_data};
        // The oldest pixel is the output register if full, otherwise the
        // RAM data itself, which gives pixel 0 one cycle after its read.
        if (r_out_v) begin
            w_head = r_out;
        end else if (r_inflight) begin
            w_head = w_in;
        end else begin
            w_head = '0;
        end
        w_xfer  = (r_out_v || r_inflight) && pixel_ready;
    end

    assign mem_rd_en   = w_rd_en;
    assign mem_addr    = w_rd_en ? r_rd_cnt[ADDR_W-1:0] : '0;
    assign pixel_valid = r_out_v || r_inflight;
    assign pixel_out   = w_head[PIX_W-1:0];
    assign sof         = w_head[PIX_W+2];
    assign eol         = w_head[PIX_W+1];
    assign eof         = w_head[PIX_W];
    assign busy        = w_run;
    assign done        = (r_state == c_DONE);

    // Frame control: IDLE waits for start, RUN ends on the eof transfer,
    // DONE lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (start) r_state <= c_RUN;
                c_RUN:   if (w_xfer && eof) r_state <= c_DONE;
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Read address and raster position of the next read to issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt   <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_inflight <= 1'b0;
            r_if_mk    <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_start) begin
                r_rd_cnt <= '0;
                r_x      <= '0;
                r_y      <= '0;
            end else if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + c_CNT_ONE;
                r_if_mk  <= w_mk;
                if (r_x == c_X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == c_Y_LAST) ? '0 : r_y + c_Y_ONE;
                end else begin
                    r_x <= r_x + c_X_ONE;
                end
            end
        end
    end

    // Output register plus skid entry; arriving RAM data is parked here
    // whenever it cannot be handed downstream in the cycle it appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_v  <= 1'b0;
            r_out    <= '0;
            r_skid_v <= 1'b0;
            r_skid   <= '0;
        end else if (!r_out_v) begin
            // Empty: RAM data bypassed this cycle; keep it only if it stalled.
            if (r_inflight && !w_xfer) begin
                r_out_v <= 1'b1;
                r_out   <= w_in;
            end
        end else if (!r_skid_v) begin
            if (w_xfer) begin
                r_out_v <= r_inflight;
                r_out   <= r_inflight ? w_in : '0;
            end else if (r_inflight) begin
                r_skid_v <= 1'b1;
                r_skid   <= w_in;
            end
        end else if (w_xfer) begin
            // Both entries full means no read was in flight.
            r_out    <= r_skid;
            r_skid_v <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_streamer
//  Purpose  : Self-checking bench for pixel_streamer: a 3x3 instance driven
//             from a vector table, directed stall/reset sequences and random
//             ready patterns, plus a 1x1 instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_streamer;

    localparam int W = 3;
    localparam int H = 3;
    localparam int N = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 3x3 instance
    logic       start_a, ready_a;
    logic       busy_a, done_a, rd_en_a, valid_a, sof_a, eol_a, eof_a;
    logic [3:0] addr_a;
    logic [7:0] rd_data_a = '0;
    logic [7:0] pix_a;
    logic [7:0] ram_a [0:15];

    // 1x1 instance
    logic       start_b, ready_b;
    logic       busy_b, done_b, rd_en_b, valid_b, sof_b, eol_b, eof_b;
    logic [0:0] addr_b;
    logic [7:0] rd_data_b = '0;
    logic [7:0] pix_b;
    int         reads_b = 0;

    pixel_streamer #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .ADDR_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_rd_data(rd_data_a),
        .pixel_out(pix_a), .pixel_valid(valid_a), .pixel_ready(ready_a),
        .sof(sof_a), .eol(eol_a), .eof(eof_a)
    );

    pixel_streamer #(.WIDTH(1), .HEIGHT(1), .PIX_W(8), .ADDR_W(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_data(rd_data_b),
        .pixel_out(pix_b), .pixel_valid(valid_b), .pixel_ready(ready_b),
        .sof(sof_b), .eol(eol_b), .eof(eof_b)
    );

    // Synchronous frame RAMs: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= ram_a[addr_a];
        if (rd_en_b) begin
            rd_data_b <= 8'hAB;
            reads_b   <= reads_b + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected markers {sof,eol,eof} of raster index i in a WxH frame.
    function automatic int exp_mk(input int i);
        int x, y;
        x = i % W;
        y = i / W;
        return ((i == 0) ? 4 : 0) + ((x == W - 1) ? 2 : 0) +
               ((x == W - 1 && y == H - 1) ? 1 : 0);
    endfunction

    typedef struct {
        bit start; bit ready;
        bit busy;  bit done; bit rd_en; int addr;
        bit valid; int pix;  bit sof;   bit eol; bit eof;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mkv(input bit st, input bit rd, input bit bz, input bit dn,
                                 input bit re, input int ad, input bit v, input int px,
                                 input bit s, input bit e, input bit f);
        vec_t r;
        r.start = st; r.ready = rd; r.busy = bz; r.done = dn; r.rd_en = re;
        r.addr = ad; r.valid = v; r.pix = px; r.sof = s; r.eol = e; r.eof = f;
        return r;
    endfunction

    // One frame on the 3x3 instance checked against a raster-order model.
    // mode: 0 random ready, 1 stall cycles 2..6, 2 toggling ready,
    //       3 ready high with start held through RUN and DONE, 4 ready high.
    task automatic run_frame(input int mode, input bit seq, input string tag);
        int got, issued, eof_cyc;
        bit held_v, fin;
        int h_pix, h_mk;
        for (int i = 0; i < N; i++)
            ram_a[i] = seq ? 8'(10 * (i + 1)) : 8'($urandom_range(0, 255));
        got = 0; issued = 0; eof_cyc = -10; held_v = 0; fin = 0; h_pix = 0; h_mk = 0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            start_a = (cyc == 0) || (mode == 3);
            case (mode)
                0:       ready_a = 1'($urandom_range(0, 1));
                1:       ready_a = !(cyc >= 2 && cyc <= 6);
                2:       ready_a = (cyc % 2 == 0);
                default: ready_a = 1'b1;
            endcase
            @(negedge clk);
            chk({tag, " busy"}, int'(busy_a), int'(cyc >= 1 && eof_cyc < 0));
            chk({tag, " done"}, int'(done_a), int'(eof_cyc >= 0 && cyc == eof_cyc + 1));
            if (rd_en_a) begin
                chk({tag, " addr"}, int'(addr_a), issued);
                issued++;
            end
            chk({tag, " occupancy<=2"}, int'(issued - got <= 2), 1);
            if (held_v) begin
                chk({tag, " hold valid"}, int'(valid_a), 1);
                chk({tag, " hold pix"}, int'(pix_a), h_pix);
                chk({tag, " hold markers"}, int'({sof_a, eol_a, eof_a}), h_mk);
            end
            if (valid_a) begin
                if (ready_a) begin
                    if (got < N) begin
                        chk({tag, " pix"}, int'(pix_a), int'(ram_a[got]));
                        chk({tag, " markers"}, int'({sof_a, eol_a, eof_a}), exp_mk(got));
                        if (got == N - 1) eof_cyc = cyc;
                    end else begin
                        chk({tag, " extra pixel"}, got, N - 1);
                    end
                    got++;
                    held_v = 0;
                end else begin
                    held_v = 1;
                    h_pix  = int'(pix_a);
                    h_mk   = int'({sof_a, eol_a, eof_a});
                end
            end
            if (eof_cyc >= 0 && cyc == eof_cyc + 1) fin = 1;
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        ready_a = 1'b0;
        chk({tag, " frame completed"}, int'(fin), 1);
        chk({tag, " pixel count"}, got, N);
        chk({tag, " read count"}, issued, N);
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; ready_a = 1'b0; start_b = 1'b0; ready_b = 1'b0;
        for (int i = 0; i < 16; i++) ram_a[i] = 8'(10 * (i + 1));

        // Ready-high frame, RAM 10..90, start at cycle 0.
        vecs[0]  = mkv(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[1]  = mkv(0, 1, 1, 0, 1, 0, 0, 0,  0, 0, 0);
        vecs[2]  = mkv(0, 1, 1, 0, 1, 1, 1, 10, 1, 0, 0);
        vecs[3]  = mkv(0, 1, 1, 0, 1, 2, 1, 20, 0, 0, 0);
        vecs[4]  = mkv(0, 1, 1, 0, 1, 3, 1, 30, 0, 1, 0);
        vecs[5]  = mkv(0, 1, 1, 0, 1, 4, 1, 40, 0, 0, 0);
        vecs[6]  = mkv(0, 1, 1, 0, 1, 5, 1, 50, 0, 0, 0);
        vecs[7]  = mkv(0, 1, 1, 0, 1, 6, 1, 60, 0, 1, 0);
        vecs[8]  = mkv(0, 1, 1, 0, 1, 7, 1, 70, 0, 0, 0);
        vecs[9]  = mkv(0, 1, 1, 0, 1, 8, 1, 80, 0, 0, 0);
        vecs[10] = mkv(0, 1, 1, 0, 0, 0, 1, 90, 0, 1, 1);
        vecs[11] = mkv(0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0);
        vecs[12] = mkv(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", int'(busy_a), 0);
        chk("reset done", int'(done_a), 0);
        chk("reset rd_en", int'(rd_en_a), 0);
        chk("reset valid", int'(valid_a), 0);
        chk("reset pix", int'(pix_a), 0);
        chk("reset markers", int'({sof_a, eol_a, eof_a}), 0);
        chk("reset valid 1x1", int'(valid_b), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven ready-high frame.
        for (int c = 0; c < 13; c++) begin
            start_a = vecs[c].start;
            ready_a = vecs[c].ready;
            @(negedge clk);
            chk($sformatf("row%0d busy", c), int'(busy_a), int'(vecs[c].busy));
            chk($sformatf("row%0d done", c), int'(done_a), int'(vecs[c].done));
            chk($sformatf("row%0d rd_en", c), int'(rd_en_a), int'(vecs[c].rd_en));
            if (vecs[c].rd_en)
                chk($sformatf("row%0d addr", c), int'(addr_a), vecs[c].addr);
            chk($sformatf("row%0d valid", c), int'(valid_a), int'(vecs[c].valid));
            if (vecs[c].valid)
                chk($sformatf("row%0d pix", c), int'(pix_a), vecs[c].pix);
            if (vecs[c].valid || !vecs[c].busy)
                chk($sformatf("row%0d markers", c), int'({sof_a, eol_a, eof_a}),
                    int'({vecs[c].sof, vecs[c].eol, vecs[c].eof}));
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        ready_a = 1'b0;

        // Stall, toggling ready, start noise then immediate restart.
        run_frame(1, 1'b1, "stall");
        run_frame(2, 1'b1, "toggle");
        run_frame(3, 1'b1, "startnoise");
        run_frame(4, 1'b1, "restart");

        // Reset while pixel 50 is presented.
        for (int i = 0; i < N; i++) ram_a[i] = 8'(10 * (i + 1));
        start_a = 1'b1; ready_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst pix50 valid", int'(valid_a), 1);
        chk("midrst pix50", int'(pix_a), 50);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst busy", int'(busy_a), 0);
        chk("midrst done", int'(done_a), 0);
        chk("midrst rd_en", int'(rd_en_a), 0);
        chk("midrst valid", int'(valid_a), 0);
        chk("midrst pix", int'(pix_a), 0);
        chk("midrst markers", int'({sof_a, eol_a, eof_a}), 0);
        @(posedge clk); #1;
        rst = 1'b0; ready_a = 1'b0;
        @(negedge clk);
        chk("midrst no done", int'(done_a), 0);
        chk("midrst idle", int'(busy_a), 0);
        @(posedge clk); #1;
        run_frame(4, 1'b1, "afterrst");

        // Random ready patterns with random frame contents.
        for (int f = 0; f < 6; f++) run_frame(0, 1'b0, $sformatf("rnd%0d", f));

        // 1x1 instance.
        start_b = 1'b1; ready_b = 1'b1;
        @(negedge clk);
        chk("one c0 busy", int'(busy_b), 0);
        chk("one c0 rd_en", int'(rd_en_b), 0);
        @(posedge clk); #1;
        start_b = 1'b0;
        @(negedge clk);
        chk("one c1 busy", int'(busy_b), 1);
        chk("one c1 rd_en", int'(rd_en_b), 1);
        chk("one c1 addr", int'(addr_b), 0);
        chk("one c1 valid", int'(valid_b), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("one c2 valid", int'(valid_b), 1);
        chk("one c2 pix", int'(pix_b), 8'hAB);
        chk("one c2 markers", int'({sof_b, eol_b, eof_b}), 7);
        chk("one c2 rd_en", int'(rd_en_b), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("one c3 done", int'(done_b), 1);
        chk("one c3 busy", int'(busy_b), 0);
        chk("one c3 valid", int'(valid_b), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("one c4 done", int'(done_b), 0);
        chk("one reads", reads_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
- Frame source for the median filter pixel path.
- Reads one WIDTH x HEIGHT 8-bit greyscale frame from a synchronous frame RAM in raster order.
- Presents the pixels as a valid/ready stream with frame and line markers.
- Replaces file-driven stimulus with a synthesizable feeder: frame RAM -> pixel_streamer -> median.

Parameters:
- WIDTH, 3, pixels per line (>=1)
- HEIGHT, 3, lines per frame (>=1)
- PIX_W, 8, bits per pixel
- ADDR_W, 4, frame RAM address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  start-of-frame request; sampled only in IDLE
- busy  out  1  high while a frame is being streamed
- done  out  1  one-cycle pulse after the last pixel transfer
- mem_rd_en  out  1  frame RAM read strobe
- mem_addr  out  ADDR_W  frame RAM read address, valid when mem_rd_en=1
- mem_rd_data  in  PIX_W  RAM data, valid exactly one cycle after mem_rd_en
- pixel_out  out  PIX_W  stream pixel
- pixel_valid  out  1  pixel_out and markers valid
- pixel_ready  in  1  downstream accepts; transfer = pixel_valid & pixel_ready at the rising edge
- sof  out  1  marks pixel 0 of the frame
- eol  out  1  marks the last pixel of each line
- eof  out  1  marks the last pixel of the frame

Behaviour:
- Reset: every output is 0 after the reset edge, FSM = IDLE, counters = 0, buffer emptied, any in-flight read discarded. Mid-frame reset aborts the frame with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1; read address counter and x/y counters cleared.
  - RUN -> DONE on the edge that transfers the eof pixel.
  - DONE -> IDLE unconditionally after one cycle.
  - start is ignored in RUN and DONE.
- busy = 1 in RUN. done = 1 in DONE only, so busy and done are never high together.
- Read issue:
  - In RUN, mem_rd_en = 1 iff reads issued < WIDTH*HEIGHT and (buffered pixels + reads in flight) < 2.
  - mem_addr increments by 1 per issued read, starting at 0.
  - Exactly WIDTH*HEIGHT reads per frame; never an address >= WIDTH*HEIGHT.
- Buffering:
  - Output register plus one skid entry, 2 pixels max. RAM data is captured the cycle after mem_rd_en.
  - With pixel_ready held high, sustained throughput is one pixel per cycle.
- Latency (ready high): start sampled at edge n -> mem_rd_en=1, mem_addr=0 during cycle n+1 -> pixel_valid=1 with pixel 0 during cycle n+2.
- Handshake rules:
  - Once pixel_valid=1, pixel_out, sof, eol and eof stay stable until a transfer.
  - pixel_valid never drops without a transfer, except on reset.
  - pixel_ready may toggle freely and may be high while pixel_valid=0 (no effect).
- Markers are tied to the pixel's raster position, independent of stalls:
  - sof = (x==0 && y==0)
  - eol = (x==WIDTH-1)
  - eof = (x==WIDTH-1 && y==HEIGHT-1)
  - x wraps at WIDTH-1 and y increments. With WIDTH=1, every pixel has eol=1. With WIDTH=HEIGHT=1, the single pixel carries sof=eol=eof=1.
- Outputs while idle: pixel_valid=0, mem_rd_en=0, markers=0.
- Widths: pixel data passes through unmodified (no arithmetic on pixel values). Counters are sized for WIDTH and HEIGHT with no overflow.

Test Plan:
- Ready held high, RAM preloaded 10,20,...,90, start pulse at cycle 0 -> pixel_valid from cycle 2; pixels 10..90 on 9 consecutive cycles; sof on 10; eol on 30, 60, 90; eof on 90; done pulse the cycle after 90; 9 reads at addresses 0..8.
- Ready low for cycles 2-6, then high -> pixel 10 held stable, at most 2 reads issued before the stall ends, no pixel lost or duplicated; full sequence 10..90 completes.
- Ready toggling 1,0,1,0 every cycle -> output is 10..90 in order; markers stay aligned with their pixels; mem_addr never reaches 9.
- start re-asserted during RUN and in the DONE cycle -> ignored, no restart; start in the following IDLE cycle begins a new frame at address 0.
- rst asserted while the 5th pixel (50) is valid -> next cycle all outputs are 0, FSM in IDLE, no done pulse; a fresh start streams 10..90 from address 0.
- WIDTH=1, HEIGHT=1 instance, RAM holds 0xAB -> one pixel 0xAB with sof=eol=eof=1, exactly one read, done pulse the next cycle.
